// File: rtl/cpu_pkg.sv
// Shared opcode, state and field-position definitions for the CPU control slice.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package cpu_pkg;

    // Opcode field is always the top three bits of the instruction word.
    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_MOV = 3'b000;
    localparam logic [OPW-1:0] OP_ADD = 3'b001;
    localparam logic [OPW-1:0] OP_SUB = 3'b010;
    localparam logic [OPW-1:0] OP_JMP = 3'b011;
    localparam logic [OPW-1:0] OP_JZ  = 3'b100;
    localparam logic [OPW-1:0] OP_NOP = 3'b101;
    localparam logic [OPW-1:0] OP_ILL = 3'b110;
    localparam logic [OPW-1:0] OP_HLT = 3'b111;

    // Control sequencer states.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Coarse grouping of opcodes by what EXEC has to do with them.
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_JUMP    = 3'd1,
        CLS_NOP     = 3'd2,
        CLS_HALT    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    // Lowest bit of the opcode field for a given instruction width.
    function automatic int op_lsb(input int iw);
        return iw - OPW;
    endfunction

    // Lowest bit of the src1/dest field; src2 sits below it at bit 0.
    function automatic int src1_lsb(input int raw);
        return raw;
    endfunction

    // The immediate spans both register fields.
    function automatic int imm_width(input int raw);
        return 2 * raw;
    endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Splits the instruction register into fields and classifies the opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; consumer samples the fields whenever it needs them.
module cpu_instr_decode
    import cpu_pkg::*;
#(
    parameter int IW  = 8,
    parameter int RAW = 2
) (
    input  logic [IW-1:0]    ir,
    output logic [OPW-1:0]   opcode,
    output logic [RAW-1:0]   src1,
    output logic [RAW-1:0]   dest,
    output logic [RAW-1:0]   src2,
    output logic [2*RAW-1:0] imm,
    output logic             alu_src_imm,
    output op_class_t        op_class,
    output logic             upd_zero,
    output logic             cond_jump
);

    localparam int OP_LSB   = op_lsb(IW);
    localparam int S1_LSB   = src1_lsb(RAW);
    localparam int IMMW     = imm_width(RAW);

    // Field extraction; dest deliberately aliases src1 (two-address format).
    assign opcode = ir[IW-1:OP_LSB];
    assign src1   = ir[S1_LSB+RAW-1:S1_LSB];
    assign dest   = ir[S1_LSB+RAW-1:S1_LSB];
    assign src2   = ir[RAW-1:0];
    assign imm    = ir[IMMW-1:0];

    // Classify the opcode and flag which ops touch Z or depend on it.
    always_comb begin
        op_class    = CLS_NOP;
        alu_src_imm = 1'b0;
        upd_zero    = 1'b0;
        cond_jump   = 1'b0;
        case (opcode)
            OP_MOV: begin
                op_class    = CLS_ALU;
                alu_src_imm = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                op_class = CLS_ALU;
                upd_zero = 1'b1;
            end
            OP_JMP: op_class = CLS_JUMP;
            OP_JZ: begin
                op_class  = CLS_JUMP;
                cond_jump = 1'b1;
            end
            OP_NOP: op_class = CLS_NOP;
            OP_ILL: op_class = CLS_ILLEGAL;
            OP_HLT: op_class = CLS_HALT;
            default: op_class = CLS_NOP;
        endcase
    end

    // Bits between the immediate and the opcode carry no meaning in this ISA.
    generate
        if (OP_LSB > IMMW) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^ir[OP_LSB-1:IMMW];
        end
    endgenerate

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch/decode/execute/write-back, owns PC, IR, Z and illegal flag.
// Latency: ALU ops 4 cycles from the accepting fetch, jumps/NOP/illegal 3, HLT 3 cycles to halted.
// Backpressure: instr_ready only in FETCH; holds pc/IR while instr_valid is low; HALT waits for resume.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int IW  = 8,
    parameter int RAW = 2,
    parameter int PCW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [PCW-1:0]   pc,
    input  logic             alu_zero,
    input  logic             resume,
    output logic [OPW-1:0]   opcode,
    output logic [RAW-1:0]   src1,
    output logic [RAW-1:0]   dest,
    output logic [RAW-1:0]   src2,
    output logic [2*RAW-1:0] imm,
    output logic             alu_src_imm,
    output logic             reg_write,
    output logic             halted,
    output logic             illegal,
    output logic             zero_flag
);

    // IW must be at least 3 + 2*RAW so the opcode and both register fields fit.

    state_t           state_q, state_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic [IW-1:0]    ir_q, ir_d;
    logic             z_q, z_d;
    logic             ill_q, ill_d;
    logic             rdy_q;

    logic             dec_src_imm;
    op_class_t        dec_class;
    logic             dec_upd_zero;
    logic             dec_cond_jump;
    logic             accept;

    cpu_instr_decode #(
        .IW  (IW),
        .RAW (RAW)
    ) u_decode (
        .ir          (ir_q),
        .opcode      (opcode),
        .src1        (src1),
        .dest        (dest),
        .src2        (src2),
        .imm         (imm),
        .alu_src_imm (dec_src_imm),
        .op_class    (dec_class),
        .upd_zero    (dec_upd_zero),
        .cond_jump   (dec_cond_jump)
    );

    // Handshake only counts once the registered ready is up, so nothing is taken while in reset.
    assign accept = (state_q == ST_FETCH) && rdy_q && instr_valid;

    // Next-state, PC, IR and flag updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        ill_d   = ill_q;
        case (state_q)
            ST_FETCH: begin
                if (accept) begin
                    ir_d    = instr;
                    pc_d    = pc_q + PCW'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (dec_class)
                    CLS_ALU: begin
                        if (dec_upd_zero) begin
                            z_d = alu_zero;
                        end
                        state_d = ST_WB;
                    end
                    CLS_JUMP: begin
                        // Overwrites the pc+1 taken at this instruction's fetch.
                        if (!dec_cond_jump || z_q) begin
                            pc_d = PCW'(imm);
                        end
                        state_d = ST_FETCH;
                    end
                    CLS_ILLEGAL: begin
                        ill_d   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_FETCH;
                endcase
            end
            ST_WB: state_d = ST_FETCH;
            ST_HALT: begin
                // Only sampled here, so a resume coincident with entry has no effect.
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State, datapath registers and the registered fetch-ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            ill_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            ill_q   <= ill_d;
            rdy_q   <= (state_d == ST_FETCH);
        end
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        instr_ready = rdy_q;
        pc          = pc_q;
        zero_flag   = z_q;
        illegal     = ill_q;
        reg_write   = (state_q == ST_WB);
        halted      = (state_q == ST_HALT);
        // IR resets to MOV's encoding, so the operand select is gated to the active window.
        alu_src_imm = dec_src_imm &&
                      ((state_q == ST_DECODE) || (state_q == ST_EXEC) || (state_q == ST_WB));
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with a write-back scoreboard and a narrow-PC twin instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       alu_zero;
    logic       resume;

    logic       instr_ready;
    logic [7:0] pc;
    logic [2:0] opcode;
    logic [1:0] src1, dest, src2;
    logic [3:0] imm;
    logic       alu_src_imm, reg_write, halted, illegal, zero_flag;

    logic       s_instr_ready;
    logic [3:0] s_pc;
    logic [2:0] s_opcode;
    logic [1:0] s_src1, s_dest, s_src2;
    logic [3:0] s_imm;
    logic       s_alu_src_imm, s_reg_write, s_halted, s_illegal, s_zero_flag;

    cpu_ctrl_fsm #(.IW(8), .RAW(2), .PCW(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .alu_zero(alu_zero), .resume(resume),
        .opcode(opcode), .src1(src1), .dest(dest), .src2(src2), .imm(imm),
        .alu_src_imm(alu_src_imm), .reg_write(reg_write), .halted(halted),
        .illegal(illegal), .zero_flag(zero_flag)
    );

    cpu_ctrl_fsm #(.IW(8), .RAW(2), .PCW(4)) dut_s (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(s_instr_ready), .pc(s_pc), .alu_zero(alu_zero), .resume(resume),
        .opcode(s_opcode), .src1(s_src1), .dest(s_dest), .src2(s_src2), .imm(s_imm),
        .alu_src_imm(s_alu_src_imm), .reg_write(s_reg_write), .halted(s_halted),
        .illegal(s_illegal), .zero_flag(s_zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dest;
        logic [3:0] imm;
        logic       src_imm;
    } wr_t;

    wr_t        wr_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] pc_m   = 8'd0;
    logic [7:0] ir_m   = 8'd0;
    logic       z_m    = 1'b0;
    logic       ill_m  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},  32'(instr_ready), 32'(0));
        chk({tag, "_pc"},   32'(pc),          32'(0));
        chk({tag, "_spc"},  32'(s_pc),        32'(0));
        chk({tag, "_wr"},   32'(reg_write),   32'(0));
        chk({tag, "_hlt"},  32'(halted),      32'(0));
        chk({tag, "_ill"},  32'(illegal),     32'(0));
        chk({tag, "_z"},    32'(zero_flag),   32'(0));
        chk({tag, "_simm"}, 32'(alu_src_imm), 32'(0));
        chk({tag, "_op"},   32'(opcode),      32'(0));
        chk({tag, "_imm"},  32'(imm),         32'(0));
        chk({tag, "_dest"}, 32'(dest),        32'(0));
    endtask

    // Called at a negedge while in FETCH; returns at the negedge where FETCH or HALT is reached again.
    task automatic run_instr(input logic [7:0] ins, input logic az, input int idle);
        logic [2:0] op;
        logic       is_alu;
        int         cyc;
        bit         done;
        wr_t        e;
        wr_t        g;
        op     = ins[7:5];
        is_alu = (op == 3'b000) || (op == 3'b001) || (op == 3'b010);

        for (int i = 0; i < idle; i++) begin
            instr_valid = 1'b0;
            instr       = 8'($urandom);
            @(negedge clk);
            chk("idle_rdy", 32'(instr_ready), 32'(1));
            chk("idle_pc",  32'(pc),          32'(pc_m));
            chk("idle_op",  32'(opcode),      32'(ir_m[7:5]));
            chk("idle_imm", 32'(imm),         32'(ir_m[3:0]));
            chk("idle_wr",  32'(reg_write),   32'(0));
        end

        chk("fetch_rdy", 32'(instr_ready), 32'(1));
        chk("fetch_pc",  32'(pc),          32'(pc_m));
        instr       = ins;
        instr_valid = 1'b1;
        alu_zero    = az;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 8'($urandom);
        ir_m        = ins;
        pc_m        = pc_m + 8'd1;
        chk("dec_pc",   32'(pc),     32'(pc_m));
        chk("dec_op",   32'(opcode), 32'(op));
        chk("dec_dest", 32'(dest),   32'(ins[3:2]));
        chk("dec_src2", 32'(src2),   32'(ins[1:0]));
        if (is_alu) begin
            e.dest    = ins[3:2];
            e.imm     = ins[3:0];
            e.src_imm = (op == 3'b000);
            wr_q.push_back(e);
        end

        cyc  = 1;
        done = 0;
        while (!done && cyc <= 8) begin
            if (cyc == 1) chk("dec_simm", 32'(alu_src_imm), 32'(op == 3'b000));
            if (reg_write) begin
                chk("wr_cyc", 32'(cyc), 32'(3));
                chk("wr_expected", 32'(wr_q.size() != 0), 32'(1));
                if (wr_q.size() != 0) begin
                    g.dest    = dest;
                    g.imm     = imm;
                    g.src_imm = alu_src_imm;
                    e         = wr_q.pop_front();
                    chk("wr_dest", 32'(g.dest),    32'(e.dest));
                    chk("wr_imm",  32'(g.imm),     32'(e.imm));
                    chk("wr_simm", 32'(g.src_imm), 32'(e.src_imm));
                end
            end
            if (instr_ready || halted) begin
                done = 1;
            end else begin
                resume = (cyc < 3);
                @(negedge clk);
                cyc++;
            end
        end
        resume = 1'b0;
        chk("no_timeout", 32'(done), 32'(1));

        if (op == 3'b001 || op == 3'b010) z_m = az;
        if (op == 3'b011 || (op == 3'b100 && z_m)) pc_m = {4'd0, ins[3:0]};
        if (op == 3'b110) ill_m = 1'b1;

        chk("latency",  32'(cyc),         32'(is_alu ? 4 : 3));
        chk("end_hlt",  32'(halted),      32'(op == 3'b111));
        chk("end_rdy",  32'(instr_ready), 32'(op != 3'b111));
        chk("end_pc",   32'(pc),          32'(pc_m));
        chk("end_spc",  32'(s_pc),        32'(pc_m[3:0]));
        chk("end_z",    32'(zero_flag),   32'(z_m));
        chk("end_ill",  32'(illegal),     32'(ill_m));
        chk("wr_drain", 32'(wr_q.size()), 32'(0));
    endtask

    initial begin
        rst         = 1'b1;
        instr       = 8'd0;
        instr_valid = 1'b0;
        alu_zero    = 1'b0;
        resume      = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 32'(instr_ready), 32'(1));
        chk("post_rst_pc",  32'(pc),          32'(0));

        run_instr(8'b000_0_1001, 1'b0, 0);  // MOV r2,#9 -> pc 1
        run_instr(8'b010_0_0110, 1'b1, 5);  // SUB, zero -> Z=1 after 5 idle cycles
        run_instr(8'b100_0_1100, 1'b0, 0);  // JZ 0xC taken
        run_instr(8'b001_0_0101, 1'b0, 0);  // ADD, nonzero -> Z=0
        run_instr(8'b100_0_1100, 1'b1, 0);  // JZ not taken
        run_instr(8'b011_0_0101, 1'b0, 0);  // JMP 5
        run_instr(8'b110_0_0011, 1'b0, 0);  // illegal at pc 5
        run_instr(8'b101_0_0000, 1'b0, 0);  // NOP, illegal stays set
        run_instr(8'b111_0_0000, 1'b0, 0);  // HLT at pc 7, resume held through entry

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_hlt", 32'(halted),      32'(1));
            chk("halt_rdy", 32'(instr_ready), 32'(0));
            chk("halt_pc",  32'(pc),          32'(8));
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume_hlt", 32'(halted),      32'(0));
        chk("resume_rdy", 32'(instr_ready), 32'(1));
        chk("resume_pc",  32'(pc),          32'(8));

        run_instr(8'b001_0_1110, 1'b1, 2);  // ADD, zero -> Z=1
        run_instr(8'b011_0_1111, 1'b0, 0);  // JMP 15
        run_instr(8'b101_0_0000, 1'b0, 0);  // NOP at 15: narrow pc wraps to 0

        // Reset asserted in EXEC of a MOV so the would-be WB cycle is cancelled.
        instr       = 8'b000_0_1011;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst   = 1'b0;
        pc_m  = 8'd0;
        ir_m  = 8'd0;
        z_m   = 1'b0;
        ill_m = 1'b0;
        @(negedge clk);
        chk("midrst_wr_after", 32'(reg_write),   32'(0));
        chk("midrst_rdy",      32'(instr_ready), 32'(1));

        run_instr(8'b000_0_0110, 1'b0, 1);  // MOV r1,#6 after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
